// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with look-ahead coordinates,
// pixel-clock enable, line/frame start strobes and a gated colour output stage.
module vga_timing_gen #(
  parameter int unsigned COLOR_BITS  = 3,
  parameter int unsigned COUNT_BITS  = 12,
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 18,
  parameter int unsigned H_SYNC      = 92,
  parameter int unsigned H_BACK      = 50,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          HSYNC_POL   = 1'b0,
  parameter bit          VSYNC_POL   = 1'b0,
  parameter int unsigned LEAD_CYCLES = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Pix_En,
  input  logic [COLOR_BITS-1:0] i_Red,
  input  logic [COLOR_BITS-1:0] i_Grn,
  input  logic [COLOR_BITS-1:0] i_Blu,
  output logic [COUNT_BITS-1:0] o_X,
  output logic [COUNT_BITS-1:0] o_Y,
  output logic [COUNT_BITS-1:0] o_HCounter,
  output logic [COUNT_BITS-1:0] o_VCounter,
  output logic                  o_Active,
  output logic                  o_HSync,
  output logic                  o_VSync,
  output logic [COLOR_BITS-1:0] o_Red,
  output logic [COLOR_BITS-1:0] o_Grn,
  output logic [COLOR_BITS-1:0] o_Blu,
  output logic                  o_Frame_Start,
  output logic                  o_Line_Start
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COUNT_BITS-1:0] HLast       = COUNT_BITS'(HTotal - 1);
  localparam logic [COUNT_BITS-1:0] VLast       = COUNT_BITS'(VTotal - 1);
  localparam logic [COUNT_BITS-1:0] HVis        = COUNT_BITS'(H_VISIBLE);
  localparam logic [COUNT_BITS-1:0] VVis        = COUNT_BITS'(V_VISIBLE);
  localparam logic [COUNT_BITS-1:0] HSyncStart  = COUNT_BITS'(H_VISIBLE + H_FRONT);
  localparam logic [COUNT_BITS-1:0] HSyncEnd    = COUNT_BITS'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COUNT_BITS-1:0] VSyncStart  = COUNT_BITS'(V_VISIBLE + V_FRONT);
  localparam logic [COUNT_BITS-1:0] VSyncEnd    = COUNT_BITS'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [COUNT_BITS-1:0] LeadX       = COUNT_BITS'(LEAD_CYCLES);
  localparam logic [COUNT_BITS-1:0] CountZero   = '0;

  logic [COUNT_BITS-1:0] h_q, h_d, v_q, v_d;
  logic [COUNT_BITS-1:0] x_q, x_d, y_q, y_d;
  logic                  active_q, active_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic [COLOR_BITS-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic                  line_start_q, line_start_d;
  logic                  frame_start_q, frame_start_d;

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    red_d         = red_q;
    grn_d         = grn_q;
    blu_d         = blu_q;
    // Strobes default low so they self-clear on every clock edge.
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (i_Pix_En) begin
      if (h_q == HLast) begin
        h_d = CountZero;
        v_d = (v_q == VLast) ? CountZero : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end

      // Look-ahead pair uses the same wrap rules, offset by LeadX from reset.
      if (x_q == HLast) begin
        x_d = CountZero;
        y_d = (y_q == VLast) ? CountZero : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end

      active_d      = (h_q < HVis) && (v_q < VVis);
      hsync_d       = ((h_q >= HSyncStart) && (h_q < HSyncEnd)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = ((v_q >= VSyncStart) && (v_q < VSyncEnd)) ? VSYNC_POL : ~VSYNC_POL;
      red_d         = i_Red;
      grn_d         = i_Grn;
      blu_d         = i_Blu;
      line_start_d  = (h_q == CountZero);
      frame_start_d = (h_q == CountZero) && (v_q == CountZero);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      h_q           <= '0;
      v_q           <= '0;
      x_q           <= LeadX;
      y_q           <= '0;
      active_q      <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      red_q         <= '0;
      grn_q         <= '0;
      blu_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      red_q         <= red_d;
      grn_q         <= grn_d;
      blu_q         <= blu_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_X           = x_q;
  assign o_Y           = y_q;
  assign o_HCounter    = h_q;
  assign o_VCounter    = v_q;
  assign o_Active      = active_q;
  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Red         = red_q & {COLOR_BITS{active_q}};
  assign o_Grn         = grn_q & {COLOR_BITS{active_q}};
  assign o_Blu         = blu_q & {COLOR_BITS{active_q}};
  assign o_Frame_Start = frame_start_q;
  assign o_Line_Start  = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a tiny 8x6 raster (LEAD 2 and LEAD 0) plus the default 800x525 raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Small raster instances A (LEAD=2) and C (LEAD=0) share inputs.
  logic        rst_a, pe_a;
  logic [2:0]  r_a, g_a, b_a;
  logic [11:0] x_a, y_a, h_a, v_a;
  logic        act_a, hs_a, vs_a, fs_a, ls_a;
  logic [2:0]  ro_a, go_a, bo_a;

  logic [11:0] x_c, y_c, h_c, v_c;
  logic        act_c, hs_c, vs_c, fs_c, ls_c;
  logic [2:0]  ro_c, go_c, bo_c;

  // Default raster instance B.
  logic        rst_b, pe_b;
  logic [2:0]  r_b, g_b, b_b;
  logic [11:0] x_b, y_b, h_b, v_b;
  logic        act_b, hs_b, vs_b, fs_b, ls_b;
  logic [2:0]  ro_b, go_b, bo_b;

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LEAD_CYCLES(2)
  ) u_a (
    .i_Clk(clk), .i_Reset(rst_a), .i_Pix_En(pe_a),
    .i_Red(r_a), .i_Grn(g_a), .i_Blu(b_a),
    .o_X(x_a), .o_Y(y_a), .o_HCounter(h_a), .o_VCounter(v_a),
    .o_Active(act_a), .o_HSync(hs_a), .o_VSync(vs_a),
    .o_Red(ro_a), .o_Grn(go_a), .o_Blu(bo_a),
    .o_Frame_Start(fs_a), .o_Line_Start(ls_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LEAD_CYCLES(0)
  ) u_c (
    .i_Clk(clk), .i_Reset(rst_a), .i_Pix_En(pe_a),
    .i_Red(r_a), .i_Grn(g_a), .i_Blu(b_a),
    .o_X(x_c), .o_Y(y_c), .o_HCounter(h_c), .o_VCounter(v_c),
    .o_Active(act_c), .o_HSync(hs_c), .o_VSync(vs_c),
    .o_Red(ro_c), .o_Grn(go_c), .o_Blu(bo_c),
    .o_Frame_Start(fs_c), .o_Line_Start(ls_c)
  );

  vga_timing_gen u_b (
    .i_Clk(clk), .i_Reset(rst_b), .i_Pix_En(pe_b),
    .i_Red(r_b), .i_Grn(g_b), .i_Blu(b_b),
    .o_X(x_b), .o_Y(y_b), .o_HCounter(h_b), .o_VCounter(v_b),
    .o_Active(act_b), .o_HSync(hs_b), .o_VSync(vs_b),
    .o_Red(ro_b), .o_Grn(go_b), .o_Blu(bo_b),
    .o_Frame_Start(fs_b), .o_Line_Start(ls_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] cr(input int k);
    return 3'(k);
  endfunction
  function automatic logic [2:0] cg(input int k);
    return 3'(k * 3 + 1);
  endfunction
  function automatic logic [2:0] cb(input int k);
    return 3'(7 - k);
  endfunction

  // Drive the colour that the k-th enabled edge should capture.
  task automatic drive_a(input int k);
    r_a = cr(k);
    g_a = cg(k);
    b_a = cb(k);
  endtask

  // Expected state of A/C after k enabled edges since reset; en says whether the
  // most recent edge was enabled (strobes only appear after an enabled edge).
  task automatic check_a(input int k, input bit en);
    int hp, vp, la;
    bit act;
    hp  = (k - 1) % 8;
    vp  = ((k - 1) / 8) % 6;
    la  = (k + 2) % 48;
    act = (hp < 4) && (vp < 3);
    chk("a_h", h_a, k % 8);
    chk("a_v", v_a, (k / 8) % 6);
    chk("a_x", x_a, la % 8);
    chk("a_y", y_a, la / 8);
    chk("a_active", act_a, act);
    chk("a_hsync", hs_a, (hp == 5) || (hp == 6));
    chk("a_vsync", vs_a, vp == 4);
    chk("a_line_start", ls_a, en && (hp == 0));
    chk("a_frame_start", fs_a, en && (hp == 0) && (vp == 0));
    chk("a_red", ro_a, act ? cr(k) : 3'd0);
    chk("a_grn", go_a, act ? cg(k) : 3'd0);
    chk("a_blu", bo_a, act ? cb(k) : 3'd0);
    chk("c_x_eq_h", x_c, k % 8);
    chk("c_y_eq_v", y_c, (k / 8) % 6);
  endtask

  task automatic check_reset_a();
    chk("rst_a_h", h_a, 0);
    chk("rst_a_v", v_a, 0);
    chk("rst_a_x", x_a, 2);
    chk("rst_a_y", y_a, 0);
    chk("rst_a_active", act_a, 0);
    chk("rst_a_hsync", hs_a, 0);
    chk("rst_a_vsync", vs_a, 0);
    chk("rst_a_red", ro_a, 0);
    chk("rst_a_grn", go_a, 0);
    chk("rst_a_blu", bo_a, 0);
    chk("rst_a_ls", ls_a, 0);
    chk("rst_a_fs", fs_a, 0);
    chk("rst_c_x", x_c, 0);
  endtask

  initial begin
    int k;
    rst_a = 1'b1;
    rst_b = 1'b1;
    pe_a  = 1'b0;
    pe_b  = 1'b0;
    drive_a(0);
    r_b = 3'b101;
    g_b = 3'b010;
    b_b = 3'b111;
    #12;

    // Reset state; B is active-low sync so deasserted level is 1.
    check_reset_a();
    chk("rst_b_h", h_b, 0);
    chk("rst_b_x", x_b, 2);
    chk("rst_b_hsync", hs_b, 1);
    chk("rst_b_vsync", vs_b, 1);
    chk("rst_b_active", act_b, 0);
    chk("rst_b_red", ro_b, 0);

    // Continuous enable over two full small frames (96 pixels).
    step();
    rst_a = 1'b0;
    pe_a  = 1'b1;
    k = 0;
    drive_a(1);
    step();
    k = 1;
    chk("first_h", h_a, 1);
    chk("first_fs", fs_a, 1);
    chk("first_active", act_a, 1);
    chk("first_red", ro_a, cr(1));
    check_a(k, 1'b1);
    for (int i = 0; i < 110; i++) begin
      drive_a(k + 1);
      step();
      k++;
      check_a(k, 1'b1);
    end

    // Enable one clock in four; colour inputs scrambled while disabled.
    for (int i = 0; i < 14; i++) begin
      pe_a = 1'b1;
      drive_a(k + 1);
      step();
      k++;
      check_a(k, 1'b1);
      pe_a = 1'b0;
      for (int j = 0; j < 3; j++) begin
        r_a = ~cr(k);
        g_a = ~cg(k);
        b_a = ~cb(k);
        step();
        check_a(k, 1'b0);
      end
    end

    // Advance to H=5, then pulse reset between clock edges.
    pe_a = 1'b1;
    for (int i = 0; i < 8 && (k % 8) != 5; i++) begin
      drive_a(k + 1);
      step();
      k++;
      check_a(k, 1'b1);
    end
    chk("pre_reset_h", h_a, 5);
    rst_a = 1'b1;
    #2;
    check_reset_a();
    rst_a = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      drive_a(k + 1);
      step();
      k++;
      check_a(k, 1'b1);
    end

    // Default raster: first two lines plus part of the third.
    step();
    rst_b = 1'b0;
    pe_b  = 1'b1;
    for (int kb = 1; kb <= 1700; kb++) begin
      int hp, la;
      bit act;
      step();
      hp  = (kb - 1) % 800;
      la  = kb + 2;
      act = hp < 640;
      chk("b_h", h_b, kb % 800);
      chk("b_v", v_b, kb / 800);
      chk("b_x", x_b, la % 800);
      chk("b_y", y_b, la / 800);
      chk("b_hsync", hs_b, !((hp >= 658) && (hp < 750)));
      chk("b_vsync", vs_b, 1);
      chk("b_active", act_b, act);
      chk("b_line_start", ls_b, hp == 0);
      chk("b_frame_start", fs_b, kb == 1);
      chk("b_red", ro_b, act ? 3'b101 : 3'b000);
      chk("b_grn", go_b, act ? 3'b010 : 3'b000);
      chk("b_blu", bo_b, act ? 3'b111 : 3'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with a colour output stage, the next generation of the team's fixed 640x480 controller. It generates horizontal and vertical counters, sync pulses of configurable polarity, an active-video flag, and look-ahead pixel coordinates, so upstream pixel sources with a known pipeline latency (block RAM, sprite logic) can present colour in time. It sits between any pixel-source module and the board VGA pins. It adds a pixel-clock enable and frame/line start strobes.

## Interface
- COLOR_BITS, 3: bits per colour channel
- COUNT_BITS, 12: width of all counters and coordinate outputs
- H_VISIBLE, 640; H_FRONT, 18; H_SYNC, 92; H_BACK, 50: horizontal segment lengths in pixels (H_TOTAL = sum = 800)
- V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical segment lengths in lines (V_TOTAL = 525)
- HSYNC_POL, 0; VSYNC_POL, 0: asserted sync level (0 = active-low)
- LEAD_CYCLES, 2: look-ahead of o_X/o_Y in pixels; legal range 0..H_TOTAL-1
- i_Clk  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_Pix_En  in  1  pixel enable; the block advances only on i_Clk edges with i_Pix_En=1
- i_Red, i_Grn, i_Blu  in  COLOR_BITS each  colour for the current counter position
- o_X, o_Y  out  COUNT_BITS  look-ahead coordinate, LEAD_CYCLES pixels ahead of the counters
- o_HCounter, o_VCounter  out  COUNT_BITS  current raster position
- o_Active  out  1  registered visible-area flag
- o_HSync, o_VSync  out  1  registered sync outputs
- o_Red, o_Grn, o_Blu  out  COLOR_BITS each  registered colour, forced to 0 outside active video
- o_Frame_Start  out  1  one-clock strobe, first pixel of a frame
- o_Line_Start  out  1  one-clock strobe, first pixel of every line, including blanking lines

## Operation
- The H counter runs 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and V increments. At (H_TOTAL-1, V_TOTAL-1) both counters wrap to 0.
- The look-ahead counter pair (o_X, o_Y) follows the same wrap rules. It resets to (LEAD_CYCLES, 0), so it always equals the counter position advanced by LEAD_CYCLES pixels modulo the frame. Example: H=798 with LEAD_CYCLES=2 gives o_X=0 and o_Y=V+1, or 0 if V=V_TOTAL-1.
- On each enabled edge the stage registers values derived from the pre-edge counters (h, v):
  - o_Active <= (h < H_VISIBLE) && (v < V_VISIBLE)
  - o_HSync <= HSYNC_POL when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC, else ~HSYNC_POL
  - o_VSync <= VSYNC_POL when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC, else ~VSYNC_POL
  - colour registers <= i_Red/i_Grn/i_Blu
- Colour outputs are the registered colour ANDed with o_Active.
- Strobes: o_Line_Start is set on an enabled edge where h=0, and o_Frame_Start where h=0 and v=0. Both clear on the next i_Clk edge regardless of i_Pix_En.
- Contract for the pixel source: the colour for coordinate (o_X, o_Y) must be on i_Red/i_Grn/i_Blu exactly LEAD_CYCLES enabled edges later.
- i_Pix_En=0: all counters and registered outputs hold, except the strobes, which still self-clear.

## Timing
- i_Reset=1 asynchronously forces:
  - counters to 0; o_X=LEAD_CYCLES, o_Y=0
  - o_Active=0; colour outputs 0; strobes 0
  - o_HSync=~HSYNC_POL, o_VSync=~VSYNC_POL (sync deasserted, not 0)
- Reset asserted mid-frame takes effect immediately, with no clock edge required. On release, the first enabled edge registers position (0,0) and advances H to 1.
- Latency: a registered output reflects the counter value one enabled edge earlier. The colour path is 1 enabled edge from input to pin.
- i_Pix_En asserted continuously gives one pixel per i_Clk.

## Test plan
- Defaults, i_Pix_En=1 for 2 frames -> line period 800 clocks; o_HSync low 92 clocks per line, asserted for registered h=658..749; o_VSync low for 1600 clocks (v=490..491); frame period 420000 clocks.
- Defaults, full frame -> o_Active high 640 consecutive clocks per line on 480 lines, 307200 clocks total; o_Frame_Start high exactly 1 clock per frame, coincident with the first o_Active rise; o_Line_Start 525 times per frame.
- Look-ahead check -> o_X == (o_HCounter+2) mod 800 every cycle; at (799,524), o_X=1 and o_Y=0; with LEAD_CYCLES=0, o_X == o_HCounter.
- Colour gating: i_Red=3'b101, i_Grn=3'b010, i_Blu=3'b111 constant -> outputs show those values only while o_Active=1, and 0 during blanking.
- i_Pix_En high 1 cycle in 4 -> line period 3200 clocks; all outputs stable between enables; each strobe still exactly 1 clock wide.
- Overrides H=4/1/2/1, V=3/1/1/1, HSYNC_POL=1, VSYNC_POL=1 -> H_TOTAL=8, V_TOTAL=6; o_HSync high only at registered h=5..6. Async reset pulsed between edges at H=5 -> immediate reset values, then restart from (0,0).
